axis_pulse_sequencer: RTL and testbench

- Scheduler that drives the pulse-measurement datapath through a programmed list of measurement configurations ("slots").
- Per slot: presents the slot's configuration word, holds the datapath in reset briefly, counts completed pulse cycles and captures each result.
- Stops early on threshold overload when so configured.
- Sits between the PS-side config/status registers and the measurement core.

---
 rtl/axis_pulse_sequencer.sv | 214 +++++++++++++++++++++
 tb/tb_axis_pulse_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : axis_pulse_sequencer
// Purpose  : Steps the pulse-measurement core through a programmed table of
//            configuration slots. For each slot it presents the slot's config
//            word, holds the core in reset for RST_CYCLES, counts completed
//            pulse cycles (phase 4 -> 0) and emits one result per completion.
//            It can stop early on an overloaded completion.
// Ports    : aclk/aresetn          clock, synchronous active-low reset
//            cfg_wr_*              config table write port (any state)
//            start/stop            sequence launch / abort pulses
//            num_active            slots to run (0 -> 1, clamped to NUM_SLOTS)
//            pulses_per_slot       completions per slot (0 -> 1)
//            abort_on_ovl          enter FAULT on an overloaded completion
//            meas_case_id/sts/overload   measurement core phase and status
//            meas_cfg_data         shadowed config word driven to the core
//            meas_aresetn          core reset, high only while running a slot
//            busy/done/fault       sequence status
//            slot_idx              slot currently being run
//            res_valid/slot/data   one-cycle result strobe with captured status
// Revision : 1.0 - initial release
// ============================================================================
module axis_pulse_sequencer #(
    parameter int PULSE_WIDTH = 16,
    parameter int NUM_SLOTS   = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int RST_CYCLES  = 2
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           cfg_wr_en,
    input  logic [$clog2(NUM_SLOTS)-1:0]   cfg_wr_slot,
    input  logic [PULSE_WIDTH*4+95:0]      cfg_wr_data,
    input  logic                           start,
    input  logic                           stop,
    input  logic [$clog2(NUM_SLOTS):0]     num_active,
    input  logic [CNT_WIDTH-1:0]           pulses_per_slot,
    input  logic                           abort_on_ovl,
    input  logic [2:0]                     meas_case_id,
    input  logic [31:0]                    meas_sts,
    input  logic                           meas_overload,
    output logic [PULSE_WIDTH*4+95:0]      meas_cfg_data,
    output logic                           meas_aresetn,
    output logic                           busy,
    output logic                           done,
    output logic                           fault,
    output logic [$clog2(NUM_SLOTS)-1:0]   slot_idx,
    output logic                           res_valid,
    output logic [$clog2(NUM_SLOTS)-1:0]   res_slot,
    output logic [31:0]                    res_data
);

    localparam int c_SLOT_W = $clog2(NUM_SLOTS);
    localparam int c_CFG_W  = PULSE_WIDTH*4 + 96;
    localparam int c_RST_W  = $clog2(RST_CYCLES + 1);

    localparam logic [c_SLOT_W:0]    c_NUM_SLOTS = (c_SLOT_W+1)'(NUM_SLOTS);
    localparam logic [c_RST_W-1:0]   c_RST_LAST  = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_RST_W-1:0]   c_RST_ONE   = c_RST_W'(1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [c_SLOT_W-1:0]  c_SLOT_ONE  = c_SLOT_W'(1);
    localparam logic [c_SLOT_W:0]    c_SLOT_ONE_W = (c_SLOT_W+1)'(1);
    localparam logic [2:0]           c_CASE_LAST = 3'd4;
    localparam logic [2:0]           c_CASE_FIRST = 3'd0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_CFG_W-1:0]     r_table [NUM_SLOTS];
    logic [c_CFG_W-1:0]     r_shadow;
    logic [c_SLOT_W-1:0]    r_slot_idx;
    logic [c_SLOT_W:0]      r_num_act;
    logic [CNT_WIDTH-1:0]   r_pps;
    logic [CNT_WIDTH-1:0]   r_pulse_cnt;
    logic [c_RST_W-1:0]     r_rst_cnt;
    logic [2:0]             r_case_prev;
    logic                   r_res_valid;
    logic [c_SLOT_W-1:0]    r_res_slot;
    logic [31:0]            r_res_data;

    logic                   w_idle_like;
    logic                   w_launch;
    logic                   w_complete;
    logic                   w_last_slot;
    logic [CNT_WIDTH-1:0]   w_cnt_inc;
    logic [CNT_WIDTH-1:0]   w_pps_eff;
    logic [c_SLOT_W:0]      w_num_act_eff;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_FAULT);
    assign w_launch    = w_idle_like && start && !stop;

    // r_case_prev is forced to 0 outside RUN, so a completion can only be
    // seen once the core has been out of reset for at least one cycle.
    // A stop in the completion cycle suppresses the result.
    assign w_complete  = (r_state == S_RUN) && (r_case_prev == c_CASE_LAST) &&
                         (meas_case_id == c_CASE_FIRST) && !stop;

    assign w_cnt_inc   = (r_pulse_cnt == '1) ? r_pulse_cnt : r_pulse_cnt + c_CNT_ONE;
    assign w_pps_eff   = (r_pps == '0) ? c_CNT_ONE : r_pps;
    assign w_last_slot = ((c_SLOT_W+1)'(r_slot_idx) + c_SLOT_ONE_W) >= r_num_act;

    assign w_num_act_eff = (num_active == '0)         ? c_SLOT_ONE_W :
                           (num_active > c_NUM_SLOTS) ? c_NUM_SLOTS  : num_active;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_FAULT: begin
                if (start) w_state_next = S_LOAD;
            end
            S_LOAD: begin
                if (r_rst_cnt == c_RST_LAST) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_complete) begin
                    if (meas_overload && abort_on_ovl) begin
                        w_state_next = S_FAULT;
                    end else if (w_cnt_inc >= w_pps_eff) begin
                        w_state_next = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                w_state_next = w_last_slot ? S_DONE : S_LOAD;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (stop) w_state_next = S_IDLE;
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_table[i] <= '0;
            end
            r_shadow    <= '0;
            r_slot_idx  <= '0;
            r_num_act   <= '0;
            r_pps       <= '0;
            r_pulse_cnt <= '0;
            r_rst_cnt   <= '0;
            r_case_prev <= '0;
            r_res_valid <= 1'b0;
            r_res_slot  <= '0;
            r_res_data  <= '0;
        end else begin
            if (cfg_wr_en) begin
                r_table[cfg_wr_slot] <= cfg_wr_data;
            end

            r_case_prev <= (r_state == S_RUN) ? meas_case_id : c_CASE_FIRST;
            r_res_valid <= w_complete;
            if (w_complete) begin
                r_res_data  <= meas_sts;
                r_res_slot  <= r_slot_idx;
                r_pulse_cnt <= w_cnt_inc;
            end

            if (w_launch) begin
                r_slot_idx <= '0;
                r_num_act  <= w_num_act_eff;
                r_pps      <= pulses_per_slot;
            end

            if (r_state == S_LOAD) begin
                // Latch once at slot entry so table writes during the slot
                // only show up on the slot's next load.
                if (r_rst_cnt == '0) begin
                    r_shadow <= r_table[r_slot_idx];
                end
                r_rst_cnt   <= r_rst_cnt + c_RST_ONE;
                r_pulse_cnt <= '0;
            end else begin
                r_rst_cnt <= '0;
            end

            if ((r_state == S_NEXT) && !w_last_slot && !stop) begin
                r_slot_idx <= r_slot_idx + c_SLOT_ONE;
            end
        end
    end

    // -------------------------------------------------------------- outputs
    assign meas_cfg_data = r_shadow;
    assign meas_aresetn  = (r_state == S_RUN);
    assign busy          = (r_state == S_LOAD) || (r_state == S_RUN);
    assign done          = (r_state == S_DONE);
    assign fault         = (r_state == S_FAULT);
    assign slot_idx      = r_slot_idx;
    assign res_valid     = r_res_valid;
    assign res_slot      = r_res_slot;
    assign res_data      = r_res_data;

endmodule
`default_nettype wire

// File: tb/tb_axis_pulse_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pulse_sequencer
// Purpose  : Directed self-checking bench for axis_pulse_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pulse_sequencer;

    localparam int c_CFG_W = 16*4 + 96;

    logic               aclk = 1'b0;
    logic               aresetn;
    logic               cfg_wr_en;
    logic [1:0]         cfg_wr_slot;
    logic [c_CFG_W-1:0] cfg_wr_data;
    logic               start;
    logic               stop;
    logic [2:0]         num_active;
    logic [15:0]        pulses_per_slot;
    logic               abort_on_ovl;
    logic [2:0]         meas_case_id;
    logic [31:0]        meas_sts;
    logic               meas_overload;
    logic [c_CFG_W-1:0] meas_cfg_data;
    logic               meas_aresetn;
    logic               busy;
    logic               done;
    logic               fault;
    logic [1:0]         slot_idx;
    logic               res_valid;
    logic [1:0]         res_slot;
    logic [31:0]        res_data;

    int n_tests = 0;
    int n_fail  = 0;

    // results and per-slot load observations gathered by the monitor
    int                 res_slot_q [$];
    logic [31:0]        res_data_q [$];
    logic [c_CFG_W-1:0] cfg_q [$];
    int                 lo_q [$];
    int                 lo_run = 0;

    axis_pulse_sequencer #(
        .PULSE_WIDTH(16), .NUM_SLOTS(4), .CNT_WIDTH(16), .RST_CYCLES(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_slot(cfg_wr_slot), .cfg_wr_data(cfg_wr_data),
        .start(start), .stop(stop), .num_active(num_active),
        .pulses_per_slot(pulses_per_slot), .abort_on_ovl(abort_on_ovl),
        .meas_case_id(meas_case_id), .meas_sts(meas_sts), .meas_overload(meas_overload),
        .meas_cfg_data(meas_cfg_data), .meas_aresetn(meas_aresetn),
        .busy(busy), .done(done), .fault(fault), .slot_idx(slot_idx),
        .res_valid(res_valid), .res_slot(res_slot), .res_data(res_data)
    );

    always #5 aclk = ~aclk;

    always @(negedge aclk) begin
        if (!aresetn) begin
            lo_run = 0;
        end else begin
            if (res_valid) begin
                res_slot_q.push_back(int'(res_slot));
                res_data_q.push_back(res_data);
            end
            if (busy && !meas_aresetn) begin
                lo_run++;
            end else begin
                if (meas_aresetn && lo_run > 0) begin
                    lo_q.push_back(lo_run);
                    cfg_q.push_back(meas_cfg_data);
                end
                lo_run = 0;
            end
        end
    end

    function automatic logic [c_CFG_W-1:0] mkw(input int i);
        logic [31:0] w;
        w = 32'hC0FE_0000 + 32'(i * 257);
        return {w, ~w, w ^ 32'h5A5A_5A5A, w, 32'(i)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic clear_q();
        res_slot_q.delete();
        res_data_q.delete();
        cfg_q.delete();
        lo_q.delete();
    endtask

    task automatic write_cfg(input int slot, input logic [c_CFG_W-1:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_slot = 2'(slot);
        cfg_wr_data = data;
        cyc(1);
        cfg_wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic wait_run(input string tag);
        int n = 0;
        while (meas_aresetn !== 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        if (meas_aresetn !== 1'b1) begin
            n_tests++; n_fail++;
            $display("FAIL %s_wait_run: meas_aresetn=%b, required 1 within 40 cycles", tag, meas_aresetn);
        end
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(done === 1'b1 || fault === 1'b1) && n < 60) begin
            cyc(1);
            n++;
        end
        if (!(done === 1'b1 || fault === 1'b1)) begin
            n_tests++; n_fail++;
            $display("FAIL %s_wait_end: done=%b fault=%b, required one high within 60 cycles", tag, done, fault);
        end
    endtask

    // phases 1..4 then 0; completion edge is the last cycle driven
    task automatic run_pulse(input logic [31:0] sts, input logic ovl);
        for (int c = 1; c <= 4; c++) begin
            meas_case_id = 3'(c);
            cyc(1);
        end
        meas_case_id  = 3'd0;
        meas_sts      = sts;
        meas_overload = ovl;
        cyc(1);
        meas_sts      = 32'h0;
        meas_overload = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        aresetn = 1'b0;
        cyc(3);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL rst_fault: got %b want 0", fault); end
        n_tests++; if (meas_aresetn !== 1'b0) begin n_fail++; $display("FAIL rst_meas_aresetn: got %b want 0", meas_aresetn); end
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_res_valid: got %b want 0", res_valid); end
        n_tests++; if ({slot_idx, res_slot, res_data} !== 36'h0) begin n_fail++; $display("FAIL rst_idx_res: got %h want 0", {slot_idx, res_slot, res_data}); end
        n_tests++; if (meas_cfg_data !== '0) begin n_fail++; $display("FAIL rst_cfg_data: got %h want 0", meas_cfg_data); end
        aresetn = 1'b1;
        cyc(1);
        // a written slot must be cleared by a later reset
        write_cfg(0, mkw(5));
        aresetn = 1'b0;
        cyc(2);
        aresetn = 1'b1;
        cyc(1);
        num_active = 3'd1; pulses_per_slot = 16'd1;
        pulse_start();
        wait_run("rst");
        n_tests++; if (meas_cfg_data !== '0) begin n_fail++; $display("FAIL rst_table_cleared: got %h want 0", meas_cfg_data); end
        run_pulse(32'h1, 1'b0);
        wait_end("rst");
    endtask

    task automatic test_sequence();
        for (int i = 0; i < 4; i++) write_cfg(i, mkw(i));
        num_active = 3'd3; pulses_per_slot = 16'd2; abort_on_ovl = 1'b0;
        clear_q();
        pulse_start();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL seq_busy_after_start: got %b want 1", busy); end
        n_tests++; if (meas_aresetn !== 1'b0) begin n_fail++; $display("FAIL seq_lat_c1: meas_aresetn got %b want 0", meas_aresetn); end
        cyc(1);
        n_tests++; if (meas_aresetn !== 1'b0) begin n_fail++; $display("FAIL seq_lat_c2: meas_aresetn got %b want 0", meas_aresetn); end
        cyc(1);
        n_tests++; if (meas_aresetn !== 1'b1) begin n_fail++; $display("FAIL seq_lat_c3: meas_aresetn got %b want 1", meas_aresetn); end
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 2; p++) begin
                wait_run("seq");
                run_pulse(32'h5000_0000 + 32'(s*16 + p), 1'b0);
            end
        end
        wait_end("seq");
        cyc(1);
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL seq_done: got %b want 1", done); end
        n_tests++; if (meas_aresetn !== 1'b0) begin n_fail++; $display("FAIL seq_done_meas_aresetn: got %b want 0", meas_aresetn); end
        n_tests++;
        if (res_slot_q.size() != 6) begin
            n_fail++; $display("FAIL seq_res_count: got %0d want 6", res_slot_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_tests++;
                if (res_slot_q[i] != i/2 || res_data_q[i] !== 32'h5000_0000 + 32'((i/2)*16 + i%2)) begin
                    n_fail++;
                    $display("FAIL seq_res_%0d: got slot %0d data %h want slot %0d data %h", i,
                             res_slot_q[i], res_data_q[i], i/2, 32'h5000_0000 + 32'((i/2)*16 + i%2));
                end
            end
        end
        n_tests++;
        if (cfg_q.size() != 3) begin
            n_fail++; $display("FAIL seq_load_count: got %0d want 3", cfg_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (cfg_q[i] !== mkw(i) || lo_q[i] != 2) begin
                    n_fail++;
                    $display("FAIL seq_load_%0d: got cfg %h low %0d want cfg %h low 2", i, cfg_q[i], lo_q[i], mkw(i));
                end
            end
        end
    endtask

    task automatic test_result_data();
        num_active = 3'd1; pulses_per_slot = 16'd1;
        pulse_start();
        wait_run("res");
        run_pulse(32'h1234_5672, 1'b0);
        n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL res_valid_high: got %b want 1", res_valid); end
        n_tests++; if (res_data !== 32'h1234_5672) begin n_fail++; $display("FAIL res_data: got %h want 12345672", res_data); end
        cyc(1);
        n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL res_valid_width: got %b want 0", res_valid); end
        wait_end("res");
    endtask

    task automatic test_overload();
        num_active = 3'd3; pulses_per_slot = 16'd2; abort_on_ovl = 1'b1;
        clear_q();
        pulse_start();
        for (int p = 0; p < 2; p++) begin
            wait_run("ovl");
            run_pulse(32'h7000_0000 + 32'(p), 1'b0);
        end
        wait_run("ovl");
        run_pulse(32'h7000_0010, 1'b1);
        n_tests++; if (res_valid !== 1'b1 || res_slot !== 2'd1 || res_data !== 32'h7000_0010) begin
            n_fail++; $display("FAIL ovl_result: got valid %b slot %0d data %h want 1 1 70000010", res_valid, res_slot, res_data); end
        n_tests++; if (fault !== 1'b1 || slot_idx !== 2'd1) begin
            n_fail++; $display("FAIL ovl_fault: got fault %b slot_idx %0d want 1 1", fault, slot_idx); end
        cyc(10);
        n_tests++; if (fault !== 1'b1 || busy !== 1'b0 || meas_aresetn !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL ovl_hold: got fault %b busy %b mrst %b done %b want 1 0 0 0", fault, busy, meas_aresetn, done); end
        n_tests++; if (cfg_q.size() != 2 || res_slot_q.size() != 3) begin
            n_fail++; $display("FAIL ovl_no_reload: got loads %0d results %0d want 2 3", cfg_q.size(), res_slot_q.size()); end
        // same stimulus without abort runs to completion
        abort_on_ovl = 1'b0;
        clear_q();
        pulse_start();
        n_tests++; if (fault !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ovl_relaunch: got fault %b busy %b want 0 1", fault, busy); end
        for (int s = 0; s < 3; s++) begin
            for (int p = 0; p < 2; p++) begin
                wait_run("ovl2");
                run_pulse(32'h7100_0000 + 32'(s*16 + p), (s == 1 && p == 0));
            end
        end
        wait_end("ovl2");
        cyc(1);
        n_tests++; if (done !== 1'b1 || fault !== 1'b0 || res_slot_q.size() != 6) begin
            n_fail++; $display("FAIL ovl_noabort: got done %b fault %b results %0d want 1 0 6", done, fault, res_slot_q.size()); end
    endtask

    task automatic test_stop();
        num_active = 3'd2; pulses_per_slot = 16'd2;
        pulse_start();
        wait_run("stop");
        clear_q();
        meas_case_id = 3'd1; cyc(1);
        meas_case_id = 3'd2; stop = 1'b1; cyc(1);
        stop = 1'b0;
        meas_case_id = 3'd4; cyc(1);
        meas_case_id = 3'd0; cyc(3);
        n_tests++; if (busy !== 1'b0 || meas_aresetn !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
            n_fail++; $display("FAIL stop_idle: got busy %b mrst %b done %b fault %b want 0 0 0 0", busy, meas_aresetn, done, fault); end
        n_tests++; if (res_slot_q.size() != 0) begin
            n_fail++; $display("FAIL stop_no_result: got %0d results want 0", res_slot_q.size()); end
        start = 1'b1; stop = 1'b1; cyc(1);
        start = 1'b0; stop = 1'b0;
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_wins_busy: got %b want 0", busy); end
        cyc(3);
        n_tests++; if (busy !== 1'b0 || meas_aresetn !== 1'b0) begin
            n_fail++; $display("FAIL stop_wins_hold: got busy %b mrst %b want 0 0", busy, meas_aresetn); end
    endtask

    task automatic test_shadow();
        write_cfg(0, mkw(0));
        num_active = 3'd1; pulses_per_slot = 16'd2;
        clear_q();
        pulse_start();
        wait_run("shd");
        write_cfg(0, mkw(9));
        n_tests++; if (meas_cfg_data !== mkw(0)) begin n_fail++; $display("FAIL shd_after_write: got %h want %h", meas_cfg_data, mkw(0)); end
        run_pulse(32'h2, 1'b0);
        pulses_per_slot = 16'd1;
        wait_run("shd");
        run_pulse(32'h3, 1'b0);
        wait_end("shd");
        cyc(1);
        n_tests++; if (done !== 1'b1 || res_slot_q.size() != 2 || meas_cfg_data !== mkw(0)) begin
            n_fail++; $display("FAIL shd_done: got done %b results %0d cfg %h want 1 2 %h", done, res_slot_q.size(), meas_cfg_data, mkw(0)); end
        pulse_start();
        wait_run("shd2");
        n_tests++; if (meas_cfg_data !== mkw(9)) begin n_fail++; $display("FAIL shd_next_start: got %h want %h", meas_cfg_data, mkw(9)); end
        run_pulse(32'h4, 1'b0);
        wait_end("shd2");
    endtask

    task automatic test_zero_counts();
        num_active = 3'd0; pulses_per_slot = 16'd0;
        clear_q();
        pulse_start();
        wait_run("zero");
        // 4 -> 1 and 1 -> 0 are not completions
        meas_case_id = 3'd4; cyc(1);
        meas_case_id = 3'd1; cyc(1);
        meas_case_id = 3'd0; cyc(2);
        n_tests++; if (res_slot_q.size() != 0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL zero_skip: got results %0d busy %b want 0 1", res_slot_q.size(), busy); end
        run_pulse(32'hAB, 1'b0);
        wait_end("zero");
        cyc(1);
        n_tests++; if (done !== 1'b1 || res_slot_q.size() != 1 || cfg_q.size() != 1) begin
            n_fail++; $display("FAIL zero_one_slot: got done %b results %0d loads %0d want 1 1 1", done, res_slot_q.size(), cfg_q.size()); end
    endtask

    task automatic test_clamp();
        num_active = 3'd7; pulses_per_slot = 16'd1;
        clear_q();
        pulse_start();
        for (int s = 0; s < 4; s++) begin
            wait_run("clamp");
            run_pulse(32'hC000_0000 + 32'(s), 1'b0);
        end
        wait_end("clamp");
        cyc(1);
        n_tests++;
        if (done !== 1'b1 || res_slot_q.size() != 4) begin
            n_fail++; $display("FAIL clamp_count: got done %b results %0d want 1 4", done, res_slot_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (res_slot_q[i] != i) begin
                    n_fail++; $display("FAIL clamp_slot_%0d: got %0d want %0d", i, res_slot_q[i], i);
                end
            end
        end
    endtask

    initial begin
        aresetn = 1'b0; cfg_wr_en = 1'b0; cfg_wr_slot = '0; cfg_wr_data = '0;
        start = 1'b0; stop = 1'b0; num_active = '0; pulses_per_slot = '0;
        abort_on_ovl = 1'b0; meas_case_id = '0; meas_sts = '0; meas_overload = 1'b0;
        test_reset();
        test_sequence();
        test_result_data();
        test_overload();
        test_stop();
        test_shadow();
        test_zero_counts();
        test_clamp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
